// File: rtl/debounce_pkg.sv
// Shared types and defaults for push-button pin readers.
// Debounce FSM states and clock-count defaults.
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_PEND = 2'd1,
    PRESSED    = 2'd2,
    REL_PEND   = 2'd3
  } db_state_t;

  // 10 ms at 50 MHz
  localparam int unsigned DB_STABLE_DEFAULT = 500000;
  // 1 s at 50 MHz
  localparam int unsigned DB_HOLD_DEFAULT   = 50000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous pin.
// Reset value is the pin's idle level so no edge is seen at reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Next values: shift the pin through two stages.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchronizer stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: clean level, press/release/long strobes.
// All outputs are registered; no combinational path from btn_raw.
module button_debounce
  import debounce_pkg::*;
#(
  parameter logic        active_low   = 1'b1,
  parameter int unsigned stable_count = DB_STABLE_DEFAULT,
  parameter int unsigned hold_count   = DB_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic toggle_out
);

  localparam int SW = $clog2(stable_count + 1);
  localparam int HW = $clog2(hold_count + 1);

  localparam logic [SW-1:0] STAB_LAST = SW'(stable_count - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(hold_count - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(hold_count);

  logic sync_q;
  logic s2;

  db_state_t     state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          tog_q, tog_d;
  logic          held;

  sync_2ff #(
    .RST_VAL(active_low)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_raw),
    .q    (sync_q)
  );

  assign s2   = active_low ? ~sync_q : sync_q;
  assign held = (state_q == PRESSED) || (state_q == REL_PEND);

  // Next state and stability count; the first disagreeing
  // sample counts as one so the flip lands stable_count
  // samples after the change reaches s2.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    unique case (state_q)
      RELEASED: begin
        stab_d = '0;
        if (s2) begin
          state_d = PRESS_PEND;
          stab_d  = SW'(1);
        end
      end
      PRESS_PEND: begin
        if (!s2) begin
          state_d = RELEASED;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = PRESSED;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      PRESSED: begin
        stab_d = '0;
        if (!s2) begin
          state_d = REL_PEND;
          stab_d  = SW'(1);
        end
      end
      REL_PEND: begin
        if (s2) begin
          state_d = PRESSED;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = RELEASED;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        stab_d  = '0;
      end
    endcase
  end

  // Hold count saturates one past the fire point so the
  // long strobe fires once; a bounce back to PRESSED keeps it.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_d == RELEASED) begin
      hold_d = '0;
    end else if (held && hold_q != HOLD_SAT) begin
      hold_d = hold_q + HW'(1);
    end
    if (held && state_d != RELEASED && hold_q == HOLD_LAST) begin
      long_d = 1'b1;
    end
  end

  // Registered output values derived from the state transition.
  always_comb begin
    level_d = (state_d == PRESSED) || (state_d == REL_PEND);
    press_d = (state_q == PRESS_PEND) && (state_d == PRESSED);
    rel_d   = (state_q == REL_PEND) && (state_d == RELEASED);
    tog_d   = tog_q ^ press_d;
  end

  // State, counters and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      stab_q  <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      tog_q   <= tog_d;
    end
  end

  assign btn_level        = level_q;
  assign press_pulse      = press_q;
  assign release_pulse    = rel_q;
  assign long_press_pulse = long_q;
  assign toggle_out       = tog_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce.
// stable_count=4, hold_count=20, active-low button.
module tb_button_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b1;
  logic btn_level, press_pulse, release_pulse;
  logic long_press_pulse, toggle_out;

  int n_vec = 0;
  int n_err = 0;
  int n_press = 0;
  int n_rel = 0;
  int n_long = 0;
  int n_ovl = 0;

  button_debounce #(
    .active_low  (1'b1),
    .stable_count(4),
    .hold_count  (20)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .btn_raw         (btn_raw),
    .btn_level       (btn_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .toggle_out      (toggle_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (press_pulse) n_press <= n_press + 1;
    if (release_pulse) n_rel <= n_rel + 1;
    if (long_press_pulse) n_long <= n_long + 1;
    if ((press_pulse && release_pulse) ||
        (press_pulse && long_press_pulse))
      n_ovl <= n_ovl + 1;
  end

  function automatic logic [4:0] outs();
    return {btn_level, press_pulse, release_pulse,
            long_press_pulse, toggle_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_chk(input string tag, input int n,
                         input logic [4:0] exp);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, 32'(outs()), 32'(exp));
    end
  endtask

  logic bpat [6];

  initial begin
    bpat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // reset with the pin toggling
    for (int i = 0; i < 8; i++) begin
      tick();
      btn_raw = 1'($urandom_range(0, 1));
      check("rst_hold", 32'(outs()), 32'd0);
    end
    btn_raw = 1'b1;
    rst_n = 1'b1;
    run_chk("rst_rel", 8, 5'b00000);

    // clean press then release
    btn_raw = 1'b0;
    run_chk("cp_wait", 5, 5'b00000);
    run_chk("cp_e5", 1, 5'b11001);
    run_chk("cp_e6", 1, 5'b10001);
    btn_raw = 1'b1;
    run_chk("cr_wait", 5, 5'b10001);
    run_chk("cr_e5", 1, 5'b00101);
    run_chk("cr_e6", 1, 5'b00001);

    // bounce, then a steady press
    for (int i = 0; i < 6; i++) begin
      btn_raw = bpat[i];
      tick();
      check("bn_pat", 32'(outs()), 32'(5'b00001));
    end
    btn_raw = 1'b1;
    run_chk("bn_settle", 6, 5'b00001);
    btn_raw = 1'b0;
    run_chk("bs_wait", 5, 5'b00001);
    run_chk("bs_e5", 1, 5'b11000);
    run_chk("bs_e6", 1, 5'b10000);
    btn_raw = 1'b1;
    run_chk("bsr_wait", 5, 5'b10000);
    run_chk("bsr_e5", 1, 5'b00100);
    run_chk("bsr_e6", 1, 5'b00000);

    // long press: 30 cycles held
    btn_raw = 1'b0;
    run_chk("lp_wait", 5, 5'b00000);
    run_chk("lp_e5", 1, 5'b11001);
    run_chk("lp_hold", 19, 5'b10001);
    run_chk("lp_e25", 1, 5'b10011);
    run_chk("lp_after", 4, 5'b10001);
    btn_raw = 1'b1;
    run_chk("lr_wait", 5, 5'b10001);
    run_chk("lr_e5", 1, 5'b00101);
    run_chk("lr_e6", 1, 5'b00001);
    check("lp_count", 32'(n_long), 32'd1);

    // fresh reset, then two short presses
    rst_n = 1'b0;
    tick();
    check("rst2", 32'(outs()), 32'd0);
    btn_raw = 1'b1;
    rst_n = 1'b1;
    run_chk("rst2_rel", 4, 5'b00000);
    for (int k = 0; k < 2; k++) begin
      btn_raw = 1'b0;
      run_chk("sp_wait", 5, k ? 5'b00001 : 5'b00000);
      run_chk("sp_e5", 1, k ? 5'b11000 : 5'b11001);
      run_chk("sp_held", 4, k ? 5'b10000 : 5'b10001);
      btn_raw = 1'b1;
      run_chk("sr_wait", 5, k ? 5'b10000 : 5'b10001);
      run_chk("sr_e5", 1, k ? 5'b00100 : 5'b00101);
      run_chk("sr_idle", 4, k ? 5'b00000 : 5'b00001);
    end
    check("sp_long", 32'(n_long), 32'd1);

    // reset during PRESS_PEND with button held
    btn_raw = 1'b0;
    run_chk("mp_pend", 3, 5'b00000);
    rst_n = 1'b0;
    #1;
    check("mp_rst", 32'(outs()), 32'd0);
    run_chk("mp_rst_hold", 3, 5'b00000);
    rst_n = 1'b1;
    run_chk("mp_wait", 5, 5'b00000);
    run_chk("mp_e5", 1, 5'b11001);
    run_chk("mp_e6", 1, 5'b10001);

    tick();
    check("n_press", 32'(n_press), 32'd6);
    check("n_rel", 32'(n_rel), 32'd5);
    check("n_long", 32'(n_long), 32'd1);
    check("overlap", 32'(n_ovl), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Samples one raw, asynchronous push-button pin and produces a clean debounced level, single-cycle press, release and long-press strobes, and a press-toggled output. It is the input-side counterpart of the LED blinker block: the blinker drives a pin from a clock divider, and this block reads a pin with a clock-based stability counter. It sits between a board switch and the display/control logic in the same `clk` domain.

## Interface
- `active_low`, default 1: 1 means a pressed button reads 0 on `btn_raw`.
- `stable_count`, default 500000: consecutive cycles of disagreement required before the debounced level flips. This is 10 ms at 50 MHz. Must be ≥ 2.
- `hold_count`, default 50000000: cycles of debounced press before the long-press strobe fires. This is 1 s at 50 MHz. Must be > `stable_count`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low; all state clears while low.
- `btn_raw` input 1: raw, asynchronous, bouncing button pin.
- `btn_level` output 1: debounced level, 1 = pressed after polarity correction.
- `press_pulse` output 1: one-cycle strobe when `btn_level` rises.
- `release_pulse` output 1: one-cycle strobe when `btn_level` falls.
- `long_press_pulse` output 1: one-cycle strobe, at most once per press.
- `toggle_out` output 1: inverts on every `press_pulse`.

## Operation
- **Synchronizer:** two flops. Their reset value is the released pin level, which is `active_low ? 1 : 0`. Polarity correction is applied after stage 2, giving `s2` with 1 = pressed.
- **FSM states:** RELEASED, PRESS_PEND, PRESSED, REL_PEND.
  - RELEASED → PRESS_PEND when `s2`=1.
  - PRESS_PEND → RELEASED when `s2`=0 (bounce); the counter clears.
  - PRESS_PEND → PRESSED when `s2`=1 and `stab_cnt`==`stable_count`-1.
  - PRESSED → REL_PEND when `s2`=0.
  - REL_PEND → PRESSED when `s2`=1 (bounce); the counter clears.
  - REL_PEND → RELEASED when `s2`=0 and `stab_cnt`==`stable_count`-1.
- **Stability counter:** `stab_cnt` increments only in the PEND states and clears on every other transition.
- **Level output:** `btn_level` = 1 in PRESSED and REL_PEND, otherwise 0.
- **Hold counter:** `hold_cnt` increments in PRESSED and REL_PEND. On the edge where it equals `hold_count`-1, `long_press_pulse` fires and the counter saturates. It clears on entry to RELEASED. A bounce in REL_PEND does not reset it.
- **Toggle:** `toggle_out` flips on the same edge on which `press_pulse` is registered.
- **Counter widths:** `$clog2(param+1)` bits. Counters never wrap.

## Timing
- **Reset values:** every output is 0, the FSM is RELEASED, and both counters are 0.
- **Registered outputs:** all outputs come directly from flops, with no combinational path from `btn_raw`.
- **Press latency:** let E0 be the first edge that samples a new stable raw value.
  - `s2` is valid after E1.
  - `btn_level` and `press_pulse` update at E(`stable_count`+1).
  - `press_pulse` is high for exactly one cycle.
- **Release latency:** `release_pulse` uses the same latency rule.
- **Long press:** `long_press_pulse` asserts `hold_count` cycles after `btn_level` rises, provided the release has not completed.
- **Bounce rejection:** any bounce shorter than `stable_count` cycles, as seen at `s2`, produces no output change.
- **Reset mid-operation:** pending counts are discarded. If the button is held through reset deassertion, a fresh `press_pulse` follows `stable_count`+2 cycles after `rst_n` rises.
- **Mutual exclusion:** `press_pulse` and `release_pulse` are never high together. `long_press_pulse` can never coincide with `press_pulse`.

## Structure
- **Package `debounce_pkg`:**
  - the `db_state_t` enum (2-bit: RELEASED=0, PRESS_PEND=1, PRESSED=2, REL_PEND=3);
  - the default constants `DB_STABLE_DEFAULT` and `DB_HOLD_DEFAULT`.
- **Sub-module `sync_2ff`:** a two-flop synchronizer with a parameterised reset value. It is reused by later pin readers.

## Test plan
All scenarios use `stable_count`=4, `hold_count`=20, `active_low`=1.
- **Reset:** hold `rst_n`=0 with `btn_raw` toggling randomly → all outputs stay 0. Release reset with `btn_raw`=1 → outputs stay 0.
- **Clean press:** drive `btn_raw` 1→0 at E0 → `btn_level`=1 and `press_pulse`=1 at E5, `press_pulse`=0 at E6, `toggle_out`=1.
- **Bounce:** raw pattern 0,0,1,0,0,1 followed by steady 1 → no pulses, `btn_level` stays 0. Then a steady 0 for 6 cycles → one `press_pulse`.
- **Long press:** hold a clean press for 30 cycles → exactly one `long_press_pulse`, 20 cycles after `btn_level` rises. Release → `release_pulse` 5 cycles after the raw edge.
- **Short press:** press for 10 cycles, then release → press and release pulses only, no `long_press_pulse`. A second identical press → `toggle_out` returns to 0.
- **Reset mid-operation:** assert `rst_n` mid-PRESS_PEND, release it with the button still held → outputs 0 during reset, then `press_pulse` 6 cycles after `rst_n` rises.
